fa_serial_seq: RTL and testbench

Bit-serial add/subtract sequencer built around the single-bit full-adder cell (tt_um_fa datapath).
- Accepts two WIDTH-bit operands with a start pulse.
- Feeds the external full adder one bit pair per clock, LSB first, and registers the carry between cycles.
- Assembles the WIDTH-bit result and reports carry-out and signed overflow with a one-cycle done pulse.
- Sits between the TT user-IO decode logic and the full-adder cell.

---
 rtl/fa_serial_seq.sv | 121 ++++++++++++
 tb/tb_fa_serial_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fa_serial_seq.sv
// Bit-serial add/subtract sequencer driving an external single-bit full adder.
// Operands are streamed LSB first; the carry is held in a register between cycles.
module fa_serial_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_fa_a,
    output logic             o_fa_b,
    output logic             o_fa_cin,
    input  logic             i_fa_sum,
    input  logic             i_fa_cout,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic [WIDTH-1:0] w_res_next;

    // Subtraction is A + ~B + 1.
    assign w_b_load   = i_sub ? ~i_op_b : i_op_b;
    assign w_cin_load = i_sub ? 1'b1 : i_cin;
    assign w_res_next = {i_fa_sum, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            o_fa_a   <= 1'b0;
            o_fa_b   <= 1'b0;
            o_fa_cin <= 1'b0;
            o_result <= '0;
            o_cout   <= 1'b0;
            o_ovf    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_state  <= StRun;
                        r_a_sh   <= i_op_a;
                        r_b_sh   <= w_b_load;
                        r_res_sh <= '0;
                        r_carry  <= w_cin_load;
                        r_cnt    <= '0;
                        // Full-adder inputs are registered copies of the shifters' LSBs.
                        o_fa_a   <= i_op_a[0];
                        o_fa_b   <= w_b_load[0];
                        o_fa_cin <= w_cin_load;
                        o_busy   <= 1'b1;
                    end else begin
                        r_state  <= StIdle;
                        o_fa_a   <= 1'b0;
                        o_fa_b   <= 1'b0;
                        o_fa_cin <= 1'b0;
                        o_busy   <= 1'b0;
                    end
                end
                StRun: begin
                    r_res_sh <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= i_fa_cout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LastCnt) begin
                        // r_carry here is the carry into the MSB.
                        r_state  <= StDone;
                        o_result <= w_res_next;
                        o_cout   <= i_fa_cout;
                        o_ovf    <= r_carry ^ i_fa_cout;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        o_fa_a   <= 1'b0;
                        o_fa_b   <= 1'b0;
                        o_fa_cin <= 1'b0;
                    end else begin
                        o_fa_a   <= r_a_sh[1];
                        o_fa_b   <= r_b_sh[1];
                        o_fa_cin <= i_fa_cout;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                    o_fa_a   <= 1'b0;
                    o_fa_b   <= 1'b0;
                    o_fa_cin <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_seq.sv
// Self-checking bench for fa_serial_seq with a behavioural full adder and arithmetic reference.
module tb_fa_serial_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sub, cin;
    logic [7:0] op_a, op_b;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic [7:0] result;
    logic       cout, ovf, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] prev_res  = 8'h00;
    logic       prev_cout = 1'b0;
    logic       prev_ovf  = 1'b0;

    always #5 clk = ~clk;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    fa_serial_seq #(.WIDTH(8), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_sub    (sub),
        .i_cin    (cin),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_fa_a   (fa_a),
        .o_fa_b   (fa_b),
        .o_fa_cin (fa_cin),
        .i_fa_sum (fa_sum),
        .i_fa_cout(fa_cout),
        .o_result (result),
        .o_cout   (cout),
        .o_ovf    (ovf),
        .o_busy   (busy),
        .o_done   (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation; optionally perturbs operands and pulses start mid-run.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic c, input bit disturb);
        logic [7:0]  bb;
        int unsigned c0, mask, cin_i, sum;
        int          sa, sb, sr;
        logic [7:0]  exp_res;
        logic        exp_cout, exp_ovf;
        bb = s ? ~b : b;
        c0 = s ? 1 : int'(c);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("result_held_after_start", {24'b0, result}, {24'b0, prev_res});
        for (int i = 0; i < 8; i++) begin
            mask  = (32'd1 << i) - 1;
            cin_i = ((a & mask) + (bb & mask) + c0) >> i;
            check("busy_run", {31'b0, busy}, 32'd1);
            check("done_run", {31'b0, done}, 32'd0);
            check("fa_a_bit", {31'b0, fa_a}, {31'b0, a[i]});
            check("fa_b_bit", {31'b0, fa_b}, {31'b0, bb[i]});
            check("fa_cin_bit", {31'b0, fa_cin}, cin_i & 1);
            if (disturb && i == 2) begin
                op_a = ~a; op_b = 8'($urandom); sub = ~s; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
            sr       = sa - sb;
        end else begin
            sum      = a + b + c0;
            exp_res  = sum[7:0];
            exp_cout = sum[8];
            sr       = sa + sb + int'(c0);
        end
        exp_ovf = (sr > 127) || (sr < -128);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_in_done", {31'b0, busy}, 32'd0);
        check("result", {24'b0, result}, {24'b0, exp_res});
        check("cout", {31'b0, cout}, {31'b0, exp_cout});
        check("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
        check("fa_idle", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
        prev_res = exp_res; prev_cout = exp_cout; prev_ovf = exp_ovf;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("result_hold", {22'b0, result, cout, ovf}, {22'b0, prev_res, prev_cout, prev_ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {19'b0, result, cout, ovf, busy, done, fa_a, fa_b, fa_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'b0, busy, done}, 32'd0);

        // Directed cases.
        run_op(8'h35, 8'h1A, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);

        // Start held high: done every 9 cycles.
        @(negedge clk);
        op_a = 8'h10; op_b = 8'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            check("b2b_done", {31'b0, done}, (k % 9 == 0) ? 32'd1 : 32'd0);
            check("b2b_busy", {31'b0, busy}, (k % 9 == 0) ? 32'd0 : 32'd1);
            if (k % 9 == 0) check("b2b_result", {24'b0, result}, 32'h30);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        prev_res = 8'h30; prev_cout = 1'b0; prev_ovf = 1'b0;
        check("b2b_drained", {30'b0, busy, done}, 32'd0);

        // Mid-run operand change and start pulse are ignored.
        run_op(8'h3C, 8'h42, 1'b0, 1'b1, 1'b1);
        run_op(8'h91, 8'h17, 1'b1, 1'b0, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-run.
        @(negedge clk);
        op_a = 8'h5A; op_b = 8'h33; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {19'b0, result, cout, ovf, busy, done, fa_a, fa_b, fa_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = 8'h00; prev_cout = 1'b0; prev_ovf = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_done_after_reset", {30'b0, busy, done}, 32'd0);
        end
        run_op(8'h35, 8'h1A, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
